// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads a NUM_REGS-word vector, streams it oldest word first.
// Optional build macro PISO_BACKTOBACK_EN lets a new vector load on the final word's edge.
module piso_word_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end
endmodule

module piso_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataIn,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  output logic [DATA_WIDTH-1:0]                serialDataOut,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy
);
  localparam int              CW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_REGS - 1);

  typedef enum logic { IDLE, SHIFT } state_t;

  state_t                              state, state_nxt;
  logic [CW-1:0]                       count, count_nxt;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] buffer;
  logic                                load_fire;
  logic                                at_last;

  assign at_last   = (count == '0);
  assign load_fire = load_valid & load_ready;

  // Every word register captures on the same load handshake.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    piso_word_reg #(.DATA_WIDTH(DATA_WIDTH)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (load_fire),
      .d   (pDataIn[i]),
      .q   (buffer[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    load_ready    = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = 1'b0;
    serialDataOut = '0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_nxt = SHIFT;
          count_nxt = LAST_IDX;
        end
      end
      SHIFT: begin
        out_valid     = 1'b1;
        busy          = 1'b1;
        serialDataOut = buffer[count];
        out_last      = at_last;
`ifdef PISO_BACKTOBACK_EN
        load_ready    = at_last & out_ready;
`else
        load_ready    = 1'b0;
`endif
        // Stall holds count, so output word and last flag stay put.
        if (out_ready) begin
          if (!at_last)        count_nxt = count - 1'b1;
          else if (load_fire)  count_nxt = LAST_IDX;
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
